frogger_key_sequencer: RTL and testbench
========================================

// Module: frogger_key_sequencer
// PURPOSE
//  Turns the raw 8-bit USB HID keycode (written by software into the keycode PIO) into discrete
//  frog move commands: one per new key press, plus frame-timed auto-repeat while the key is held.
//  Sits between the PIO out_port and the frog motion logic; hands one command at a time over a
//  valid/ready handshake so hops are never lost or doubled by keycode timing.
// PARAMETERS
//  CNT_W         6   width of frame-tick repeat counter
//  REPEAT_DELAY  12  frame ticks from press to first repeat; 0 disables auto-repeat
//  REPEAT_RATE   6   frame ticks between subsequent repeats; must be >=1
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  asynchronous active-low reset
//  keycode     in   8  current HID keycode from PIO (0x00 = no key)
//  frame_tick  in   1  one-cycle pulse per video frame (vsync)
//  game_en     in   1  1 = gameplay active; 0 = suppress all commands
//  move_ready  in   1  motion logic accepts the pending command
//  move_valid  out  1  command pending
//  move_dir    out  2  0=up 1=left 2=down 3=right; valid only while move_valid=1
//  key_held    out  1  a mapped key is currently held (state != IDLE)
// BEHAVIOUR
//  - Reset: move_valid=0, move_dir=0, key_held=0, state=IDLE, counter=0, kc_q=0.
//  - keycode registered once (kc_q); decode from kc_q: 0x1A W->up, 0x04 A->left, 0x16 S->down,
//    0x07 D->right; all other codes unmapped (treated as no key).
//  - Latency: keycode change at edge N -> kc_q at N+1 -> move_valid=1 after edge N+2.
//  - States: IDLE, DELAY, REPEAT; key_held=1 in DELAY/REPEAT.
//    IDLE:   mapped key -> PRESS issue, cnt=REPEAT_DELAY, go DELAY.
//    DELAY:  unmapped -> IDLE, cnt=0. Different mapped code -> PRESS issue, reload, stay DELAY.
//            frame_tick & cnt==1 -> REPEAT issue, cnt=REPEAT_RATE, go REPEAT;
//            frame_tick & cnt>1 -> cnt-1. REPEAT_DELAY==0: cnt stays 0, no repeat ever.
//    REPEAT: same as DELAY but reload REPEAT_RATE on each repeat; new mapped code -> DELAY.
//  - Counter decrements only on frame_tick; never wraps below 0.
//  - Pending slot (one entry): issue sets move_valid=1, move_dir=dir.
//    move_valid & move_ready -> slot cleared next edge unless a new issue same cycle (then reloaded,
//    move_valid stays 1). PRESS issue while slot full & !ready: overwrites move_dir (latest wins).
//    REPEAT issue while slot full & !ready: dropped; counter still reloads.
//  - Key change and frame_tick same cycle: key change wins, counter reloaded, tick ignored.
//  - game_en=0: state forced IDLE, cnt=0, move_valid cleared next edge; held key on game_en
//    rising edge counts as a new PRESS (one cycle after game_en=1 observed).
//  - Async reset mid-operation clears everything immediately; no command survives reset.
// CONFIGURATION
//  FROGGER_KEYSEQ_ARROWS_EN: defined -> arrow codes also map: 0x52 up, 0x50 left, 0x51 down,
//  0x4F right, identical timing; switching WASD<->arrow of same direction counts as a new
//  code (new PRESS). Undefined -> arrow codes are unmapped (treated as no key).
// TESTING  (bench params REPEAT_DELAY=4, REPEAT_RATE=2, frame_tick every 10 clks, game_en=1)
//  1 reset, keycode=0x00 -> move_valid=0, key_held=0 for 100 clks; frame_tick has no effect.
//  2 keycode 0x00->0x1A at edge N, move_ready=1 -> move_valid=1, move_dir=0 after edge N+2,
//    for exactly 1 clk; key_held=1.
//  3 hold 0x07, ready=1 -> 1st cmd dir=3 at press, 2nd on 4th frame_tick, then every 2nd tick;
//    release -> key_held=0 next edge, no further cmds.
//  4 move_ready=0: press 0x04 then 0x16 -> single pending cmd dir=2; held-key repeats dropped;
//    ready=1 -> exactly one handshake.
//  5 key change to 0x1A on same cycle as frame_tick and pending handshake -> move_valid stays 1,
//    dir=0, counter=4.
//  6 game_en=0 while holding 0x1A -> move_valid=0, key_held=0; game_en=1 -> new PRESS dir=0;
//    with FROGGER_KEYSEQ_ARROWS_EN, 0x4F -> dir=3; without it, 0x4F -> no command.

Source files
------------

// File: rtl/frogger_key_sequencer_if.sv
// Keycode-to-move command bus for frogger_key_sequencer: PIO keycode, frame timing and
// game enable in; one-entry valid/ready move command out.
interface frogger_key_sequencer_if;
   logic [7:0] keycode;
   logic       frame_tick;
   logic       game_en;
   logic       move_ready;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       key_held;

   modport master (
      output keycode, frame_tick, game_en, move_ready,
      input  move_valid, move_dir, key_held
   );

   modport slave (
      input  keycode, frame_tick, game_en, move_ready,
      output move_valid, move_dir, key_held
   );
endinterface

// File: rtl/frogger_key_sequencer.sv
// Converts HID keycodes into frog move commands (press + frame-timed auto-repeat).
// Optional FROGGER_KEYSEQ_ARROWS_EN: arrow keycodes map alongside WASD.
module frogger_key_sequencer #(
   parameter int unsigned CNT_W        = 6,
   parameter int unsigned REPEAT_DELAY = 12,
   parameter int unsigned REPEAT_RATE  = 6
) (
   input logic                    clk,
   input logic                    reset_n,
   frogger_key_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [7:0]       kc_q, kc_d;
   logic [7:0]       held_q, held_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [1:0]       dir_q, dir_d;

   logic       mapped;
   logic [1:0] dir;
   logic       press;
   logic       rpt;

   always_comb begin
      mapped = 1'b1;
      dir    = 2'd0;
      case (kc_q)
         8'h1A:   dir = 2'd0;
         8'h04:   dir = 2'd1;
         8'h16:   dir = 2'd2;
         8'h07:   dir = 2'd3;
`ifdef FROGGER_KEYSEQ_ARROWS_EN
         8'h52:   dir = 2'd0;
         8'h50:   dir = 2'd1;
         8'h51:   dir = 2'd2;
         8'h4F:   dir = 2'd3;
`endif
         default: mapped = 1'b0;
      endcase
   end

   // Key change is tested before frame_tick so a simultaneous tick is ignored.
   always_comb begin
      kc_d    = bus.keycode;
      state_d = state_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      press   = 1'b0;
      rpt     = 1'b0;
      if (!bus.game_en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mapped) begin
                  press   = 1'b1;
                  cnt_d   = DELAY_LD;
                  held_d  = kc_q;
                  state_d = ST_DELAY;
               end
            end
            default: begin
               if (!mapped) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (kc_q != held_q) begin
                  press   = 1'b1;
                  cnt_d   = DELAY_LD;
                  held_d  = kc_q;
                  state_d = ST_DELAY;
               end else if (bus.frame_tick) begin
                  if (cnt_q == CNT_ONE) begin
                     rpt     = 1'b1;
                     cnt_d   = RATE_LD;
                     state_d = ST_REPEAT;
                  end else if (cnt_q > CNT_ONE) begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end
         endcase
      end
   end

   // Presses always land (latest wins); repeats only fill a slot that is free this cycle.
   always_comb begin
      valid_d = valid_q;
      dir_d   = dir_q;
      if (valid_q && bus.move_ready) begin
         valid_d = 1'b0;
      end
      if (press) begin
         valid_d = 1'b1;
         dir_d   = dir;
      end else if (rpt && (!valid_q || bus.move_ready)) begin
         valid_d = 1'b1;
         dir_d   = dir;
      end
      if (!bus.game_en) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kc_q    <= '0;
         held_q  <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         dir_q   <= 2'd0;
      end else begin
         kc_q    <= kc_d;
         held_q  <= held_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
      end
   end

   assign bus.move_valid = valid_q;
   assign bus.move_dir   = dir_q;
   assign bus.key_held   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frogger_key_sequencer.sv
// Bench for frogger_key_sequencer: directed scenarios plus random keycode traffic, checked
// every cycle against a press/tick-count reference model. Honours FROGGER_KEYSEQ_ARROWS_EN.
module tb_frogger_key_sequencer;

   localparam int RD = 4;
   localparam int RR = 2;

   logic clk;
   logic reset_n;

   frogger_key_sequencer_if bus ();

   frogger_key_sequencer #(
      .CNT_W       (6),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int hs_cnt = 0;

   // Reference model: held key code (-1 = none), frame ticks since its press, pending queue.
   logic [7:0] m_kc;
   int         m_held;
   int         m_ticks;
   logic [1:0] m_q[$];

   function automatic logic decode(input logic [7:0] k, output logic [1:0] d);
      d = 2'd0;
      case (k)
         8'h1A: begin d = 2'd0; return 1'b1; end
         8'h04: begin d = 2'd1; return 1'b1; end
         8'h16: begin d = 2'd2; return 1'b1; end
         8'h07: begin d = 2'd3; return 1'b1; end
`ifdef FROGGER_KEYSEQ_ARROWS_EN
         8'h52: begin d = 2'd0; return 1'b1; end
         8'h50: begin d = 2'd1; return 1'b1; end
         8'h51: begin d = 2'd2; return 1'b1; end
         8'h4F: begin d = 2'd3; return 1'b1; end
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_kc    = 8'h00;
      m_held  = -1;
      m_ticks = 0;
      m_q.delete();
   endtask

   task automatic model_edge(input logic [7:0] kc_in, input logic tick, input logic en,
                             input logic rdy);
      logic [1:0] d;
      logic       mp;
      logic       pr;
      logic       rp;
      pr = 1'b0;
      rp = 1'b0;
      mp = decode(m_kc, d);
      if (!en || !mp) begin
         m_held = -1;
      end else if (m_held != int'(m_kc)) begin
         pr      = 1'b1;
         m_held  = int'(m_kc);
         m_ticks = 0;
      end else if (tick && RD != 0) begin
         m_ticks++;
         if (m_ticks == RD || (m_ticks > RD && ((m_ticks - RD) % RR) == 0)) rp = 1'b1;
      end
      if (m_q.size() > 0 && rdy) m_q.delete();
      if (!en) begin
         m_q.delete();
      end else if (pr) begin
         m_q.delete();
         m_q.push_back(d);
      end else if (rp && m_q.size() == 0) begin
         m_q.push_back(d);
      end
      m_kc = kc_in;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_model();
      check("move_valid", {7'd0, bus.move_valid}, {7'd0, m_q.size() > 0});
      if (m_q.size() > 0) check("move_dir", {6'd0, bus.move_dir}, {6'd0, m_q[0]});
      check("key_held", {7'd0, bus.key_held}, {7'd0, m_held >= 0});
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
   task automatic step(input logic [7:0] kc, input logic en, input logic rdy);
      logic tick;
      tick           = ((cyc % 10) == 9);
      bus.keycode    = kc;
      bus.game_en    = en;
      bus.move_ready = rdy;
      bus.frame_tick = tick;
      #1;
      if (bus.move_valid && rdy) hs_cnt++;
      @(posedge clk);
      model_edge(kc, tick, en, rdy);
      #1;
      cyc++;
      check_model();
   endtask

   logic [7:0] pool[8] = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h52, 8'h4F, 8'h33};
   logic [7:0] r_kc;
   logic       r_en;
   logic       r_rdy;

   initial begin
      reset_n        = 1'b0;
      bus.keycode    = 8'h00;
      bus.game_en    = 1'b1;
      bus.move_ready = 1'b1;
      bus.frame_tick = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset_valid", {7'd0, bus.move_valid}, 8'd0);
      check("reset_dir", {6'd0, bus.move_dir}, 8'd0);
      check("reset_held", {7'd0, bus.key_held}, 8'd0);
      reset_n = 1'b1;

      // Idle with no key: ticks must not create commands
      repeat (100) step(8'h00, 1'b1, 1'b1);

      // Press W: command two edges after keycode is applied, lasts one clock
      step(8'h1A, 1'b1, 1'b1);
      check("w_lat1_valid", {7'd0, bus.move_valid}, 8'd0);
      step(8'h1A, 1'b1, 1'b1);
      check("w_lat2_valid", {7'd0, bus.move_valid}, 8'd1);
      check("w_lat2_dir", {6'd0, bus.move_dir}, 8'd0);
      check("w_lat2_held", {7'd0, bus.key_held}, 8'd1);
      step(8'h1A, 1'b1, 1'b1);
      check("w_one_clk", {7'd0, bus.move_valid}, 8'd0);
      repeat (5) step(8'h00, 1'b1, 1'b1);

      // Hold D with auto-repeat, then release
      repeat (80) step(8'h07, 1'b1, 1'b1);
      repeat (3) step(8'h00, 1'b1, 1'b1);
      check("release_held", {7'd0, bus.key_held}, 8'd0);
      repeat (30) step(8'h00, 1'b1, 1'b1);

      // Stalled consumer: A then S, repeats dropped, one handshake on release of stall
      repeat (3) step(8'h04, 1'b1, 1'b0);
      repeat (60) step(8'h16, 1'b1, 1'b0);
      check("stall_dir", {6'd0, bus.move_dir}, 8'd2);
      repeat (3) step(8'h00, 1'b1, 1'b0);
      hs_cnt = 0;
      repeat (6) step(8'h00, 1'b1, 1'b1);
      check("stall_handshakes", hs_cnt[7:0], 8'd1);

      // Key change coinciding with frame_tick and a handshake
      repeat (5) step(8'h07, 1'b1, 1'b0);
      while ((cyc % 10) != 8) step(8'h07, 1'b1, 1'b0);
      step(8'h1A, 1'b1, 1'b0);
      step(8'h1A, 1'b1, 1'b1);
      check("chg_tick_valid", {7'd0, bus.move_valid}, 8'd1);
      check("chg_tick_dir", {6'd0, bus.move_dir}, 8'd0);
      repeat (40) step(8'h1A, 1'b1, 1'b1);

      // game_en drop while holding W, re-enable, then arrow key
      repeat (8) step(8'h1A, 1'b0, 1'b0);
      check("gate_valid", {7'd0, bus.move_valid}, 8'd0);
      check("gate_held", {7'd0, bus.key_held}, 8'd0);
      step(8'h1A, 1'b1, 1'b1);
      check("reen_valid", {7'd0, bus.move_valid}, 8'd1);
      check("reen_dir", {6'd0, bus.move_dir}, 8'd0);
      step(8'h4F, 1'b1, 1'b1);
      step(8'h4F, 1'b1, 1'b1);
`ifdef FROGGER_KEYSEQ_ARROWS_EN
      check("arrow_valid", {7'd0, bus.move_valid}, 8'd1);
      check("arrow_dir", {6'd0, bus.move_dir}, 8'd3);
`else
      check("arrow_valid", {7'd0, bus.move_valid}, 8'd0);
      check("arrow_held", {7'd0, bus.key_held}, 8'd0);
`endif
      repeat (20) step(8'h4F, 1'b1, 1'b1);

      // Random traffic
      r_kc = 8'h00;
      r_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) r_kc = pool[$urandom_range(7)];
         if ($urandom_range(149) == 0) r_en = ~r_en;
         r_rdy = ($urandom_range(9) < 7);
         step(r_kc, r_en, r_rdy);
      end

      // Asynchronous reset while a command is pending
      repeat (3) step(8'h16, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", {7'd0, bus.move_valid}, 8'd0);
      check("async_dir", {6'd0, bus.move_dir}, 8'd0);
      check("async_held", {7'd0, bus.key_held}, 8'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      model_reset();
      repeat (30) step(8'h16, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
